nfc_acg_arbiter: RTL and testbench
==================================

NFC_ACG_ARBITER -- requirements
Module: nfc_acg_arbiter

Interface
REQ-001 Parameter NumberOfWays, default 4, width of the way-select buses.
REQ-002 Parameter NumberOfClients, default 4, number of command blocks sharing the ACG.
REQ-003 Parameter TimeoutCycles, default 16'hFFFF, maximum BUSY cycles before a forced release.
REQ-004 iSystemClock  in  1  sole clock; all logic on its rising edge.
REQ-005 iReset  in  1  synchronous, active-low reset.
REQ-006 iClientReq  in  NumberOfClients  per-client request (client oStart), sampled every cycle.
REQ-007 iClientLastStep  in  NumberOfClients  per-client command-complete flag.
REQ-008 iClientACG_Command  in  8*NumberOfClients  client i in slice [8i+7:8i]; same slicing rule for all flattened buses below.
REQ-009 iClientACG_CommandOption  in  3*NumberOfClients  per-client command option.
REQ-010 iClientACG_TargetWay  in  NumberOfWays*NumberOfClients  per-client target way.
REQ-011 iClientACG_NumOfData  in  16*NumberOfClients  per-client data count.
REQ-012 iClientACG_CASelect  in  NumberOfClients  per-client CA select.
REQ-013 iClientACG_CAData  in  40*NumberOfClients  per-client CA data.
REQ-014 oClientACG_Ready  out  8*NumberOfClients  ACG ready fanned back; granted client only.
REQ-015 oClientACG_LastStep  out  8*NumberOfClients  ACG last-step fanned back; granted client only.
REQ-016 oACG_Command / oACG_CommandOption / oACG_TargetWay / oACG_NumOfData / oACG_CASelect / oACG_CAData  out  8/3/NumberOfWays/16/1/40  muxed to the ACG.
REQ-017 iACG_Ready, iACG_LastStep  in  8 each  from the ACG.
REQ-018 oGrant  out  NumberOfClients  one-hot registered grant.
REQ-019 oBusy  out  1  high in GRANT, BUSY, RELEASE.
REQ-020 oTimeout  out  1  one-cycle pulse on forced release.

Function
REQ-021 FSM states: IDLE, GRANT, BUSY, RELEASE.
REQ-022 IDLE -> GRANT when (iClientReq | rPending) != 0; else stays IDLE.
REQ-023 Winner: round-robin, first set bit at or above rPointer, wrapping from NumberOfClients-1 to 0; registered into oGrant on the IDLE->GRANT edge.
REQ-024 GRANT -> BUSY unconditionally after 1 cycle; oACG_* carry the granted client's signals from GRANT onward (1-cycle grant latency from request).
REQ-025 BUSY -> RELEASE on iClientLastStep of the granted client, or when the BUSY counter reaches TimeoutCycles-1.
REQ-026 RELEASE -> IDLE after 1 cycle; rPointer <= granted index + 1 (mod NumberOfClients); oGrant <= 0.
REQ-027 With no grant: oACG_Command=0, CommandOption=0, TargetWay=0, NumOfData=0, CASelect=1, CAData=0.
REQ-028 Non-granted clients receive oClientACG_Ready=0 and oClientACG_LastStep=0 at all times.
REQ-029 Requests from non-granted clients while oBusy=1 set the matching rPending bit; a bit clears when that client is granted.
REQ-030 Request and LastStep in the same cycle from the granted client: LastStep wins, no re-grant until the next IDLE.
REQ-031 BUSY counter 16-bit, cleared on entry to BUSY, saturating; oTimeout pulses in the RELEASE cycle of a forced release only.
REQ-032 iClientLastStep from a non-granted client is ignored.

Reset
REQ-033 iReset low at a clock edge: state IDLE, oGrant=0, rPointer=0, rPending=0, counter=0, oBusy=0, oTimeout=0, oACG_* at REQ-027 values; applies mid-transaction, requests are dropped.

Structure
REQ-034 State encodings, ACG command-bit constants and the default CA values go in the shared NFC package.
REQ-035 Round-robin priority picker is a sub-module, nfc_rr_picker (request vector, pointer in; one-hot grant out; combinational).

Verification
REQ-036 Single request: iClientReq=4'b0100 one cycle -> oGrant=4'b0100 next cycle, oACG_CAData=client 2 data, LastStep -> IDLE 2 cycles later, rPointer=3.
REQ-037 Simultaneous: iClientReq=4'b1111 from reset -> grants served in order 0,1,2,3, each after previous RELEASE.
REQ-038 Wrap: rPointer=3, iClientReq=4'b1001 -> client 3 granted, then client 0.
REQ-039 Timeout: TimeoutCycles=16, granted client never asserts LastStep -> RELEASE after 16 BUSY cycles, oTimeout=1 for 1 cycle.
REQ-040 Isolation: iACG_Ready=8'h7F during client 1 grant -> oClientACG_Ready slice 1 = 8'h7F, all other slices = 0.
REQ-041 Reset mid-BUSY: iReset=0 one cycle -> all outputs at REQ-033 values next cycle, pending request not served.

Source files
------------

// File: rtl/nfc_acg_arbiter_pkg.sv
// nfc_acg_arbiter_pkg
//   Shared definitions for the NFC ACG arbiter: FSM state encoding, the
//   values driven onto the ACG command bus while nobody owns it, and the
//   width of the BUSY watchdog counter.
package nfc_acg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } nfc_acg_state_t;

  // ACG bus values presented while no client is granted.
  localparam logic [7:0]  ACG_CMD_NONE       = 8'h00;
  localparam logic [2:0]  ACG_OPT_NONE       = 3'b000;
  localparam logic [15:0] ACG_NUMDATA_NONE   = 16'h0000;
  localparam logic        ACG_CASEL_DEFAULT  = 1'b1;
  localparam logic [39:0] ACG_CADATA_DEFAULT = 40'h00_0000_0000;

  localparam int BUSY_CNT_W = 16;
  localparam logic [BUSY_CNT_W-1:0] BUSY_CNT_MAX = '1;

  // Width of an index into a client vector; at least one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nfc_acg_arbiter_if.sv
// nfc_acg_arbiter_if
//   Bundles the client-side command buses and the ACG-side bus of the
//   arbiter. Client buses are flattened: client i owns slice [W*i +: W].
//
//   Handshake: iClientReq is a level request sampled every cycle; the
//   client is served once its bit appears in oGrant. From that point the
//   ACG sees the client's command fields, and only the owning client gets
//   iACG_Ready / iACG_LastStep echoed back. Ownership ends on the client's
//   iClientLastStep (sampled while BUSY) or on the watchdog timeout.
//
//   slave  : arbiter side
//   master : client/ACG side (drives requests and ACG status)
interface nfc_acg_arbiter_if #(
  parameter int NumberOfWays    = 4,
  parameter int NumberOfClients = 4
);
  logic [NumberOfClients-1:0]              iClientReq;
  logic [NumberOfClients-1:0]              iClientLastStep;
  logic [8*NumberOfClients-1:0]            iClientACG_Command;
  logic [3*NumberOfClients-1:0]            iClientACG_CommandOption;
  logic [NumberOfWays*NumberOfClients-1:0] iClientACG_TargetWay;
  logic [16*NumberOfClients-1:0]           iClientACG_NumOfData;
  logic [NumberOfClients-1:0]              iClientACG_CASelect;
  logic [40*NumberOfClients-1:0]           iClientACG_CAData;
  logic [8*NumberOfClients-1:0]            oClientACG_Ready;
  logic [8*NumberOfClients-1:0]            oClientACG_LastStep;

  logic [7:0]              oACG_Command;
  logic [2:0]              oACG_CommandOption;
  logic [NumberOfWays-1:0] oACG_TargetWay;
  logic [15:0]             oACG_NumOfData;
  logic                    oACG_CASelect;
  logic [39:0]             oACG_CAData;
  logic [7:0]              iACG_Ready;
  logic [7:0]              iACG_LastStep;

  modport slave (
    input  iClientReq, iClientLastStep, iClientACG_Command,
           iClientACG_CommandOption, iClientACG_TargetWay,
           iClientACG_NumOfData, iClientACG_CASelect, iClientACG_CAData,
           iACG_Ready, iACG_LastStep,
    output oClientACG_Ready, oClientACG_LastStep,
           oACG_Command, oACG_CommandOption, oACG_TargetWay,
           oACG_NumOfData, oACG_CASelect, oACG_CAData
  );

  modport master (
    output iClientReq, iClientLastStep, iClientACG_Command,
           iClientACG_CommandOption, iClientACG_TargetWay,
           iClientACG_NumOfData, iClientACG_CASelect, iClientACG_CAData,
           iACG_Ready, iACG_LastStep,
    input  oClientACG_Ready, oClientACG_LastStep,
           oACG_Command, oACG_CommandOption, oACG_TargetWay,
           oACG_NumOfData, oACG_CASelect, oACG_CAData
  );
endinterface

// File: rtl/nfc_acg_arbiter_rr_picker.sv
// nfc_rr_picker
//   Combinational round-robin picker: returns the first set request bit at
//   or above iPointer, wrapping from N-1 back to 0, as a one-hot vector.
//   Ports: iReq (request vector), iPointer (highest-priority index),
//          oGrant (one-hot winner, zero when iReq is zero).
module nfc_rr_picker #(
  parameter int N    = 4,
  parameter int PtrW = 2
) (
  input  logic [N-1:0]    iReq,
  input  logic [PtrW-1:0] iPointer,
  output logic [N-1:0]    oGrant
);

  logic            found;
  logic [PtrW-1:0] idx;

  always_comb begin
    oGrant = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = PtrW'((int'(iPointer) + k) % N);
      if (!found && iReq[idx]) begin
        oGrant[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nfc_acg_arbiter.sv
// nfc_acg_arbiter
//   Shares one ACG between NumberOfClients command blocks. Round-robin
//   arbitration, one owner at a time, with a BUSY watchdog that forces a
//   release after TimeoutCycles cycles without a last-step.
//   Ports:
//     iSystemClock  sole clock, rising edge
//     iReset        synchronous, active-low reset
//     bus           client and ACG buses (slave side)
//     oGrant        one-hot registered grant
//     oBusy         high while a client owns the ACG (GRANT/BUSY/RELEASE)
//     oTimeout      one-cycle pulse in the RELEASE cycle of a forced release
//     oState        FSM state, for debug
module nfc_acg_arbiter
  import nfc_acg_arbiter_pkg::*;
#(
  parameter int          NumberOfWays    = 4,
  parameter int          NumberOfClients = 4,
  parameter logic [15:0] TimeoutCycles   = 16'hFFFF
) (
  input  logic                       iSystemClock,
  input  logic                       iReset,
  nfc_acg_arbiter_if.slave           bus,
  output logic [NumberOfClients-1:0] oGrant,
  output logic                       oBusy,
  output logic                       oTimeout,
  output nfc_acg_state_t             oState
);

  localparam int N    = NumberOfClients;
  localparam int W    = NumberOfWays;
  localparam int PtrW = ptr_width(N);
  localparam logic [BUSY_CNT_W-1:0] TimeoutLast = TimeoutCycles - 16'd1;

  nfc_acg_state_t        state_q, state_d;
  logic [N-1:0]          grant_q, grant_d;
  logic [N-1:0]          pending_q, pending_d;
  logic [PtrW-1:0]       pointer_q, pointer_d;
  logic [BUSY_CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic                  timeout_q, timeout_d;

  logic [N-1:0]    requests;
  logic [N-1:0]    pick;
  logic [PtrW-1:0] grant_idx;
  logic            owner_last;
  logic            busy_expired;

  logic [7:0]   acg_cmd;
  logic [2:0]   acg_opt;
  logic [W-1:0] acg_way;
  logic [15:0]  acg_num;
  logic         acg_casel;
  logic [39:0]  acg_cadata;
  logic [8*N-1:0] cl_ready;
  logic [8*N-1:0] cl_last;

  // Requests remembered while the ACG was owned compete alongside live ones.
  assign requests = bus.iClientReq | pending_q;

  nfc_rr_picker #(
    .N    (N),
    .PtrW (PtrW)
  ) u_picker (
    .iReq     (requests),
    .iPointer (pointer_q),
    .oGrant   (pick)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) grant_idx = PtrW'(i);
    end
  end

  // Last-step from any client other than the owner is masked off here.
  assign owner_last   = |(bus.iClientLastStep & grant_q);
  assign busy_expired = (busy_cnt_q == TimeoutLast);

  // State register
  always_ff @(posedge iSystemClock) begin
    if (!iReset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      pending_q  <= '0;
      pointer_q  <= '0;
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      pending_q  <= pending_d;
      pointer_q  <= pointer_d;
      busy_cnt_q <= busy_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    pending_d  = pending_q;
    pointer_d  = pointer_q;
    busy_cnt_d = busy_cnt_q;
    timeout_d  = 1'b0;

    // The owner's own request is dropped: it must re-request after IDLE.
    if (state_q != ST_IDLE) pending_d = pending_q | (bus.iClientReq & ~grant_q);

    unique case (state_q)
      ST_IDLE: begin
        if (|requests) begin
          state_d   = ST_GRANT;
          grant_d   = pick;
          pending_d = pending_q & ~pick;
        end
      end
      ST_GRANT: begin
        state_d    = ST_BUSY;
        busy_cnt_d = '0;
      end
      ST_BUSY: begin
        if (busy_cnt_q != BUSY_CNT_MAX) busy_cnt_d = busy_cnt_q + 1'b1;
        // A genuine last-step beats a coincident timeout.
        if (owner_last) begin
          state_d = ST_RELEASE;
        end else if (busy_expired) begin
          state_d   = ST_RELEASE;
          timeout_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d   = ST_IDLE;
        grant_d   = '0;
        pointer_d = (grant_idx == PtrW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    acg_cmd    = ACG_CMD_NONE;
    acg_opt    = ACG_OPT_NONE;
    acg_way    = '0;
    acg_num    = ACG_NUMDATA_NONE;
    acg_casel  = ACG_CASEL_DEFAULT;
    acg_cadata = ACG_CADATA_DEFAULT;
    cl_ready   = '0;
    cl_last    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        acg_cmd    = bus.iClientACG_Command[8*i +: 8];
        acg_opt    = bus.iClientACG_CommandOption[3*i +: 3];
        acg_way    = bus.iClientACG_TargetWay[W*i +: W];
        acg_num    = bus.iClientACG_NumOfData[16*i +: 16];
        acg_casel  = bus.iClientACG_CASelect[i];
        acg_cadata = bus.iClientACG_CAData[40*i +: 40];
        cl_ready[8*i +: 8] = bus.iACG_Ready;
        cl_last[8*i +: 8]  = bus.iACG_LastStep;
      end
    end
  end

  assign bus.oACG_Command       = acg_cmd;
  assign bus.oACG_CommandOption = acg_opt;
  assign bus.oACG_TargetWay     = acg_way;
  assign bus.oACG_NumOfData     = acg_num;
  assign bus.oACG_CASelect      = acg_casel;
  assign bus.oACG_CAData        = acg_cadata;
  assign bus.oClientACG_Ready    = cl_ready;
  assign bus.oClientACG_LastStep = cl_last;

  assign oGrant   = grant_q;
  assign oBusy    = (state_q != ST_IDLE);
  assign oTimeout = timeout_q;
  assign oState   = state_q;

endmodule

// File: tb/tb_nfc_acg_arbiter.sv
// tb_nfc_acg_arbiter
//   Directed scenarios with literal expectations, then randomized traffic,
//   all checked every cycle against an ownership-lifetime model.
module tb_nfc_acg_arbiter;
  import nfc_acg_arbiter_pkg::*;

  localparam int NC = 4;
  localparam int NW = 4;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nfc_acg_arbiter_if #(.NumberOfWays(NW), .NumberOfClients(NC)) bus();

  logic [NC-1:0]  grant;
  logic           busy;
  logic           tmo;
  nfc_acg_state_t st;

  nfc_acg_arbiter #(
    .NumberOfWays    (NW),
    .NumberOfClients (NC),
    .TimeoutCycles   (16'(TO))
  ) dut (
    .iSystemClock (clk),
    .iReset       (rst_n),
    .bus          (bus),
    .oGrant       (grant),
    .oBusy        (busy),
    .oTimeout     (tmo),
    .oState       (st)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks who owns the ACG and how many cycles have passed since the grant
  // edge: age 0 is the grant cycle, ages 1.. are busy cycles, and the owner
  // leaves one cycle after its last-step or its TO-th busy cycle.
  logic [NC-1:0] exp_q[$];
  bit            model_on = 0;
  int            m_owner = -1;
  int            m_age = 0;
  int            m_rel = -1;
  bit            m_to_rel = 0;
  int            m_ptr = 0;
  logic [NC-1:0] m_pend = '0;
  logic [NC-1:0] m_want;
  int            m_c;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_on = 1;
      m_owner  = -1;
      m_pend   = '0;
      m_ptr    = 0;
      m_rel    = -1;
      m_to_rel = 0;
    end else if (model_on) begin
      if (m_owner < 0) begin
        m_want = bus.iClientReq | m_pend;
        for (int k = 0; k < NC; k++) begin
          m_c = (m_ptr + k) % NC;
          if (m_owner < 0 && m_want[m_c]) m_owner = m_c;
        end
        if (m_owner >= 0) begin
          m_pend[m_owner] = 1'b0;
          m_age    = 0;
          m_rel    = -1;
          m_to_rel = 0;
          exp_q.push_back(NC'(1) << m_owner);
        end
      end else begin
        m_pend = m_pend | (bus.iClientReq & ~(NC'(1) << m_owner));
        if (m_age == m_rel) begin
          m_ptr   = (m_owner + 1) % NC;
          m_owner = -1;
        end else begin
          if (m_age >= 1 && m_rel < 0) begin
            if (bus.iClientLastStep[m_owner]) m_rel = m_age + 1;
            else if (m_age == TO) begin
              m_rel    = m_age + 1;
              m_to_rel = 1;
            end
          end
          m_age++;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  nfc_acg_state_t e_st;
  logic [NC-1:0]  e_grant;
  logic [NC-1:0]  q_grant;
  logic [31:0]    e_ready;
  logic [31:0]    e_last;

  always @(negedge clk) begin
    if (model_on) begin
      if (m_owner < 0) begin
        e_st    = ST_IDLE;
        e_grant = '0;
        e_ready = '0;
        e_last  = '0;
        chk("m_cmd",    bus.oACG_Command, 0);
        chk("m_opt",    bus.oACG_CommandOption, 0);
        chk("m_way",    bus.oACG_TargetWay, 0);
        chk("m_num",    bus.oACG_NumOfData, 0);
        chk("m_casel",  bus.oACG_CASelect, 1);
        chk("m_cadata", bus.oACG_CAData, 0);
      end else begin
        e_st    = (m_age == 0) ? ST_GRANT : (m_age == m_rel) ? ST_RELEASE : ST_BUSY;
        e_grant = NC'(1) << m_owner;
        e_ready = 32'(bus.iACG_Ready) << (8 * m_owner);
        e_last  = 32'(bus.iACG_LastStep) << (8 * m_owner);
        chk("m_cmd",    bus.oACG_Command, bus.iClientACG_Command[8*m_owner +: 8]);
        chk("m_opt",    bus.oACG_CommandOption, bus.iClientACG_CommandOption[3*m_owner +: 3]);
        chk("m_way",    bus.oACG_TargetWay, bus.iClientACG_TargetWay[NW*m_owner +: NW]);
        chk("m_num",    bus.oACG_NumOfData, bus.iClientACG_NumOfData[16*m_owner +: 16]);
        chk("m_casel",  bus.oACG_CASelect, bus.iClientACG_CASelect[m_owner]);
        chk("m_cadata", bus.oACG_CAData, bus.iClientACG_CAData[40*m_owner +: 40]);
      end
      chk("m_state",   st, e_st);
      chk("m_grant",   grant, e_grant);
      chk("m_busy",    busy, (m_owner >= 0));
      chk("m_timeout", tmo, (m_owner >= 0 && m_age == m_rel && m_to_rel));
      chk("m_cl_ready", bus.oClientACG_Ready, e_ready);
      chk("m_cl_last",  bus.oClientACG_LastStep, e_last);
      if (st == ST_GRANT) begin
        q_grant = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk("grant_order", grant, q_grant);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic init_inputs();
    bus.iClientReq      = '0;
    bus.iClientLastStep = '0;
    bus.iACG_Ready      = '0;
    bus.iACG_LastStep   = '0;
    for (int i = 0; i < NC; i++) begin
      bus.iClientACG_Command[8*i +: 8]        = 8'hA0 + 8'(i);
      bus.iClientACG_CommandOption[3*i +: 3]  = 3'(i);
      bus.iClientACG_TargetWay[NW*i +: NW]    = NW'(1) << i;
      bus.iClientACG_NumOfData[16*i +: 16]    = 16'h0100 + 16'(i);
      bus.iClientACG_CASelect[i]              = i[0];
      bus.iClientACG_CAData[40*i +: 40]       = 40'hC0_0000_0000 + 40'(i);
    end
  endtask

  // Starts at a falling edge, returns at the first falling edge in state want.
  task automatic wait_state(input string name, input nfc_acg_state_t want, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (st !== want && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, st, want);
  endtask

  // Called at a falling edge while the owner is BUSY.
  task automatic pulse_last(input int c);
    #1 bus.iClientLastStep[c] = 1'b1;
    @(negedge clk);
    chk("last_release", st, ST_RELEASE);
    #1 bus.iClientLastStep[c] = 1'b0;
  endtask

  task automatic serve(input string name, input int c);
    wait_state({name, "_grant"}, ST_GRANT, 20);
    chk({name, "_who"}, grant, NC'(1) << c);
    wait_state({name, "_busy"}, ST_BUSY, 4);
    pulse_last(c);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_busy;

  initial begin
    init_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", tmo, 0);
    chk("rst_casel", bus.oACG_CASelect, 1);
    chk("rst_state", st, ST_IDLE);
    #1 rst_n = 1'b1;

    // Single request from client 2 for one cycle.
    @(negedge clk);
    #1 bus.iClientReq = 4'b0100;
    @(negedge clk);
    chk("r036_grant", grant, 4'b0100);
    chk("r036_cadata", bus.oACG_CAData, 40'hC0_0000_0002);
    chk("r036_cmd", bus.oACG_Command, 8'hA2);
    #1 bus.iClientReq = '0;
    wait_state("r036_busy", ST_BUSY, 4);
    pulse_last(2);
    @(negedge clk);
    chk("r036_idle", busy, 0);
    chk("r036_grant0", grant, 0);

    // Wrap: pointer now 3, clients 3 and 0 request.
    #1 bus.iClientReq = 4'b1001;
    @(negedge clk);
    chk("r038_first", grant, 4'b1000);
    wait_state("r038_busy", ST_BUSY, 4);
    pulse_last(3);
    @(negedge clk);
    chk("r038_gap", busy, 0);
    @(negedge clk);
    chk("r038_second", grant, 4'b0001);
    #1 bus.iClientReq = '0;
    wait_state("r038_busy2", ST_BUSY, 4);
    pulse_last(0);
    @(negedge clk);

    // Isolation of ACG ready to client 1.
    #1 bus.iClientReq = 4'b0010;
    @(negedge clk);
    chk("r040_grant", grant, 4'b0010);
    #1 begin
      bus.iClientReq = '0;
      bus.iACG_Ready = 8'h7F;
    end
    @(negedge clk);
    chk("r040_ready", bus.oClientACG_Ready, 32'h0000_7F00);
    pulse_last(1);
    bus.iACG_Ready = '0;
    @(negedge clk);

    // Timeout: client 0 never signals last-step.
    #1 bus.iClientReq = 4'b0001;
    @(negedge clk);
    chk("r039_grant", grant, 4'b0001);
    #1 bus.iClientReq = '0;
    n_busy = 0;
    @(negedge clk);
    while (st == ST_BUSY && n_busy < 40) begin
      n_busy++;
      @(negedge clk);
    end
    chk("r039_busy_cycles", n_busy, 16);
    chk("r039_release", st, ST_RELEASE);
    chk("r039_timeout", tmo, 1);
    @(negedge clk);
    chk("r039_pulse_end", tmo, 0);
    chk("r039_idle", busy, 0);

    // All four request from reset: served 0,1,2,3.
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 begin
      rst_n = 1'b1;
      bus.iClientReq = 4'b1111;
    end
    for (int c = 0; c < NC; c++) serve("r037", c);
    bus.iClientReq = '0;

    // Reset while client 0 (from pending) is busy: nothing else gets served.
    wait_state("r041_grant", ST_GRANT, 6);
    wait_state("r041_busy", ST_BUSY, 4);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("r041_grant", grant, 0);
    chk("r041_busy", busy, 0);
    chk("r041_timeout", tmo, 0);
    chk("r041_state", st, ST_IDLE);
    chk("r041_cmd", bus.oACG_Command, 0);
    chk("r041_casel", bus.oACG_CASelect, 1);
    chk("r041_cadata", bus.oACG_CAData, 0);
    chk("r041_ready", bus.oClientACG_Ready, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("r041_no_serve", st, ST_IDLE);
    end

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      #1 begin
        rst_n = ($urandom_range(0, 299) != 0);
        for (int i = 0; i < NC; i++) begin
          bus.iClientReq[i]      = ($urandom_range(0, 3) == 0);
          bus.iClientLastStep[i] = ($urandom_range(0, 7) == 0);
        end
        bus.iACG_Ready               = 8'($urandom);
        bus.iACG_LastStep            = 8'($urandom);
        bus.iClientACG_Command       = $urandom;
        bus.iClientACG_CommandOption = 12'($urandom);
        bus.iClientACG_TargetWay     = 16'($urandom);
        bus.iClientACG_NumOfData     = {$urandom, $urandom};
        bus.iClientACG_CASelect      = 4'($urandom);
        bus.iClientACG_CAData        = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
    end
    #1 begin
      rst_n = 1'b1;
      bus.iClientReq = '0;
    end
    repeat (3) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
